// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 single-precision divider z = a / b
// Restoring mantissa division, one quotient bit per clock, then one rounding cycle.
module fp_div_seq #(
  parameter int BIAS = 127,
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z,
  output logic [7:0]  status
);

  typedef enum logic [2:0] {IDLE, UNPACK, CALC, ROUND, DONE} state_t;

  state_t             state;
  logic [31:0]        a_q, b_q;
  logic [2:0]         rnd_q;
  logic [24:0]        r;
  logic [23:0]        mb;
  logic [25:0]        q;
  logic signed [9:0]  e;
  logic [4:0]         cnt;

  // Operand classification; denormals are flushed to zero.
  logic sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign sign   = a_q[31] ^ b_q[31];
  assign a_zero = (a_q[30:23] == 8'd0);
  assign b_zero = (b_q[30:23] == 8'd0);
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

  logic [25:0] diff;
  logic        ge;
  assign diff = {1'b0, r} - {2'b00, mb};
  assign ge   = ~diff[25];

  logic [2:0]        mode;
  logic [22:0]       norm_frac, frac_r;
  logic              g, s, inc, big_inf, min_norm;
  logic signed [9:0] exp_n, exp_r;
  logic [23:0]       sum;
  logic [31:0]       z_rnd;
  logic [7:0]        st_rnd;

  always_comb begin
    mode = (rnd_q > 3'd5) ? 3'd0 : rnd_q;
    if (q[25]) begin
      norm_frac = q[24:2];
      g         = q[1];
      s         = q[0] | (r != 25'd0);
      exp_n     = e;
    end else begin
      norm_frac = q[23:1];
      g         = q[0];
      s         = (r != 25'd0);
      exp_n     = e - 10'sd1;
    end
    case (mode)
      3'd0:    inc = g & (s | norm_frac[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = ~sign & (g | s);
      3'd3:    inc = sign & (g | s);
      3'd4:    inc = g;
      default: inc = g | s;
    endcase
    sum      = {1'b0, norm_frac} + {23'd0, inc};
    frac_r   = sum[22:0];
    exp_r    = exp_n + $signed({9'd0, sum[23]});
    big_inf  = (mode == 3'd0) || (mode == 3'd4) || (mode == 3'd5) ||
               ((mode == 3'd2) && !sign) || ((mode == 3'd3) && sign);
    min_norm = (mode == 3'd5) || ((mode == 3'd2) && !sign) || ((mode == 3'd3) && sign);
    if (exp_r >= 10'sd255) begin
      z_rnd  = big_inf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7FFFFF};
      st_rnd = big_inf ? 8'h32 : 8'h30;
    end else if (exp_r <= 10'sd0) begin
      z_rnd  = min_norm ? {sign, 8'h01, 23'd0} : {sign, 31'd0};
      st_rnd = min_norm ? 8'h28 : 8'h29;
    end else begin
      z_rnd  = {sign, exp_r[7:0], frac_r};
      st_rnd = {2'b00, g | s, 5'b00000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      z         <= 32'd0;
      status    <= 8'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rnd_q     <= 3'd0;
      r         <= 25'd0;
      mb        <= 24'd0;
      q         <= 26'd0;
      e         <= 10'sd0;
      cnt       <= 5'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= a;
          b_q      <= b;
          rnd_q    <= rnd;
          in_ready <= 1'b0;
          state    <= UNPACK;
        end
        UNPACK: begin
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            z <= 32'h7FC00000; status <= 8'h04; out_valid <= 1'b1; state <= DONE;
          end else if (b_zero && !a_inf) begin
            z <= {sign, 8'hFF, 23'd0}; status <= 8'h42; out_valid <= 1'b1; state <= DONE;
          end else if (a_inf) begin
            z <= {sign, 8'hFF, 23'd0}; status <= 8'h02; out_valid <= 1'b1; state <= DONE;
          end else if (a_zero || b_inf) begin
            z <= {sign, 31'd0}; status <= 8'h01; out_valid <= 1'b1; state <= DONE;
          end else begin
            r     <= {2'b01, a_q[22:0]};
            mb    <= {1'b1, b_q[22:0]};
            q     <= 26'd0;
            e     <= $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'(BIAS);
            cnt   <= 5'd0;
            state <= CALC;
          end
        end
        CALC: begin
          q   <= {q[24:0], ge};
          r   <= {(ge ? diff[23:0] : r[23:0]), 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) state <= ROUND;
        end
        ROUND: begin
          z         <= z_rnd;
          status    <= st_rnd;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [2:0]  rnd = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic [7:0]  status;

  int n_checks = 0;
  int n_pass   = 0;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one operation, scramble the inputs after accept, time the result,
  // optionally stall the consumer, then complete the handshake.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] rv, input logic [31:0] exp_z,
                        input logic [7:0] exp_st, input int exp_lat, input int hold);
    int lat;
    int w;
    logic [31:0] z0;
    logic [7:0]  s0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    a = av; b = bv; rnd = rv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; rnd = 3'd3;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " z"}, z, exp_z);
    check({tag, " status"}, 32'(status), 32'(exp_st));
    z0 = z; s0 = status;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {31'd0, out_valid & ~in_ready}, 32'd1);
      check({tag, " hold z"}, z, z0);
      check({tag, " hold st"}, 32'(status), 32'(s0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drop"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(in_ready), 32'd1);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset z", z, 32'd0);
    check("reset status", 32'(status), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("6/2",       32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, 28, 0);
    run_op("1/3 rne",   32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 8'h20, 28, 0);
    run_op("1/3 rz",    32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 8'h20, 28, 0);
    run_op("1/3 rn7",   32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 8'h20, 28, 0);
    run_op("-1/3 rdn",  32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAB, 8'h20, 28, 0);
    run_op("1/0",       32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 8'h42, 1, 0);
    run_op("0/0",       32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04, 1, 0);
    run_op("-inf/2",    32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h02, 1, 0);
    run_op("0/-2",      32'h00000000, 32'hC0000000, 3'd0, 32'h80000000, 8'h01, 1, 0);
    run_op("nan/1",     32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04, 1, 0);
    run_op("ovf rne",   32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 8'h32, 28, 0);
    run_op("ovf rz",    32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 8'h30, 28, 0);
    run_op("unf rne",   32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 8'h29, 28, 0);
    run_op("unf rup",   32'h00800000, 32'h40000000, 3'd2, 32'h00800000, 8'h28, 28, 0);
    run_op("stall",     32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00, 28, 5);

    // Reset in the middle of a division must discard it.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; rnd = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no stale result", 32'(seen), 32'd0);
    run_op("after rst", 32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 8'h20, 28, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
